// File: rtl/disp_pkg.sv
// Shared types, glyph codes and active-low segment patterns
// for the dual-bank 7-segment scan scheduler.
package disp_pkg;

    // Display modes of the scheduler
    typedef enum logic [2:0] {
        SHOW_DATA,
        MSG_WRONG,
        MSG_EXPIRE,
        MSG_UNLOCK,
        LOCKED
    } disp_state_e;

    // Glyph codes: 0..15 are hex digits, the rest are letters/symbols
    typedef logic [4:0] glyph_t;

    localparam glyph_t G_BLANK = 5'd16;
    localparam glyph_t G_DASH  = 5'd17;
    localparam glyph_t G_E     = 5'd18;
    localparam glyph_t G_R     = 5'd19;
    localparam glyph_t G_T     = 5'd20;
    localparam glyph_t G_O     = 5'd21;
    localparam glyph_t G_U     = 5'd22;
    localparam glyph_t G_P     = 5'd23;
    localparam glyph_t G_N     = 5'd24;
    localparam glyph_t G_L     = 5'd25;
    localparam glyph_t G_C     = 5'd26;
    localparam glyph_t G_D     = 5'd27;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_T     = 7'h07;
    localparam logic [6:0] SEG_O     = 7'h40;
    localparam logic [6:0] SEG_U     = 7'h63;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_L     = 7'h47;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    // Preemption rank; a higher rank may interrupt a lower one
    function automatic logic [2:0] prio_of(input disp_state_e st);
        logic [2:0] p;
        unique case (st)
            SHOW_DATA:  p = 3'd0;
            MSG_WRONG:  p = 3'd1;
            MSG_UNLOCK: p = 3'd2;
            MSG_EXPIRE: p = 3'd3;
            default:    p = 3'd4;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/disp_scan_sched_seg_glyph_rom.sv
// Combinational glyph-code to active-low 7-segment pattern ROM.
// One instance drives each display bank.
module seg_glyph_rom (
    input  logic [4:0] code,
    output logic [6:0] seg
);
    import disp_pkg::*;

    // Hex codes go through the shared decoder, letters via the table
    always_comb begin
        seg = SEG_BLANK;
        if (!code[4]) begin
            seg = hex_to_seg(code[3:0]);
        end else begin
            unique case (code)
                G_DASH:  seg = SEG_DASH;
                G_E:     seg = SEG_E;
                G_R:     seg = SEG_R;
                G_T:     seg = SEG_T;
                G_O:     seg = SEG_O;
                G_U:     seg = SEG_U;
                G_P:     seg = SEG_P;
                G_N:     seg = SEG_N;
                G_L:     seg = SEG_L;
                G_C:     seg = SEG_C;
                G_D:     seg = SEG_D;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/disp_scan_sched.sv
// Dual-bank 7-segment scan scheduler with prioritised,
// time-limited status messages and a blinking lockout view.
module disp_scan_sched #(
    parameter int REFRESH_DIV  = 100000,
    parameter int MSG_HOLD     = 250,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lock,
    input  logic        unlock,
    input  logic        expire,
    input  logic [1:0]  wrng_att,
    input  logic [15:0] user_otp,
    input  logic [15:0] lfsr_otp,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [3:0]  an1,
    output logic [3:0]  an2,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);
    import disp_pkg::*;

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int HW = $clog2(MSG_HOLD + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MSG_HOLD - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic          ftick_q, ftick_d;

    disp_state_e   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    logic          lock_h_q, unlock_h_q, expire_h_q;
    logic [1:0]    wrng_h_q;

    logic [6:0]    seg1_q, seg1_d, seg2_q, seg2_d;
    logic [3:0]    an1_q, an1_d, an2_q, an2_d;

    logic          slot_tick;
    logic          lock_rise, unlock_rise, expire_rise, wrong_ev;
    logic          lock_enter;
    logic          ev_valid;
    disp_state_e   ev_state;
    logic [19:0]   word1, word2;
    logic [4:0]    code1, code2;
    logic [6:0]    rom1_seg, rom2_seg;
    logic          dark;

    assign slot_tick = (presc_q == PRESC_LAST);

    // Free-running digit scan: prescaler, digit index, frame pulse
    always_comb begin
        presc_d = slot_tick ? '0 : presc_q + 1'b1;
        digit_d = slot_tick ? digit_q + 2'd1 : digit_q;
        ftick_d = slot_tick && (digit_q == 2'd3);
    end

    // Edge detection against last-cycle history; a clear to 0 is silent
    always_comb begin
        lock_rise   = lock & ~lock_h_q;
        unlock_rise = unlock & ~unlock_h_q;
        expire_rise = expire & ~expire_h_q;
        wrong_ev    = (wrng_att != wrng_h_q) && (wrng_att != 2'd0);
        lock_enter  = lock && (lock_rise || state_q != LOCKED);
        ev_valid    = 1'b1;
        ev_state    = SHOW_DATA;
        if (expire_rise) begin
            ev_state = MSG_EXPIRE;
        end else if (unlock_rise) begin
            ev_state = MSG_UNLOCK;
        end else if (wrong_ev) begin
            ev_state = MSG_WRONG;
        end else begin
            ev_valid = 1'b0;
        end
    end

    // FSM state, message hold and blink phase registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SHOW_DATA;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Next state: lock level dominates, then preemption, then timeout
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (lock) begin
            state_d = LOCKED;
            hold_d  = '0;
            if (lock_enter) begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b0;
            end else if (ftick_q) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end else if (state_q == LOCKED) begin
            state_d = SHOW_DATA;
        end else if (ev_valid &&
                     prio_of(ev_state) >= prio_of(state_q)) begin
            state_d = ev_state;
            hold_d  = '0;
        end else if (state_q != SHOW_DATA && ftick_q) begin
            if (hold_q == HOLD_LAST) begin
                state_d = SHOW_DATA;
                hold_d  = '0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Per-state glyph words, packed {digit3, digit2, digit1, digit0}
    always_comb begin
        word1 = {4{G_BLANK}};
        word2 = {4{G_BLANK}};
        unique case (state_q)
            SHOW_DATA: begin
                word1 = {1'b0, user_otp[15:12], 1'b0, user_otp[11:8],
                         1'b0, user_otp[7:4],   1'b0, user_otp[3:0]};
                word2 = {1'b0, lfsr_otp[15:12], 1'b0, lfsr_otp[11:8],
                         1'b0, lfsr_otp[7:4],   1'b0, lfsr_otp[3:0]};
            end
            MSG_WRONG: begin
                word1 = {G_E, G_R, G_R, G_BLANK};
                word2 = {G_BLANK, G_BLANK, G_BLANK, 3'b000, wrng_att};
            end
            MSG_EXPIRE: begin
                word1 = {G_T, G_O, G_U, G_T};
                word2 = {4{G_DASH}};
            end
            MSG_UNLOCK: begin
                word1 = {G_O, G_P, G_E, G_N};
                word2 = {4{G_DASH}};
            end
            default: begin
                word1 = {G_L, G_O, G_C, G_D};
                word2 = {4{G_DASH}};
            end
        endcase
        code1 = word1[5*int'(digit_q) +: 5];
        code2 = word2[5*int'(digit_q) +: 5];
    end

    seg_glyph_rom u_rom1 (
        .code (code1),
        .seg  (rom1_seg)
    );

    seg_glyph_rom u_rom2 (
        .code (code2),
        .seg  (rom2_seg)
    );

    // Pin drive: blank everything during the blink OFF phase
    always_comb begin
        dark   = (state_q == LOCKED) && blink_ph_q;
        seg1_d = dark ? SEG_BLANK : rom1_seg;
        seg2_d = dark ? SEG_BLANK : rom2_seg;
        an1_d  = dark ? 4'hF : ~(4'b0001 << digit_q);
        an2_d  = an1_d;
    end

    // Scan, input history and registered pin outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            digit_q    <= 2'd0;
            ftick_q    <= 1'b0;
            lock_h_q   <= 1'b0;
            unlock_h_q <= 1'b0;
            expire_h_q <= 1'b0;
            wrng_h_q   <= 2'd0;
            seg1_q     <= SEG_BLANK;
            seg2_q     <= SEG_BLANK;
            an1_q      <= 4'hF;
            an2_q      <= 4'hF;
        end else begin
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            ftick_q    <= ftick_d;
            lock_h_q   <= lock;
            unlock_h_q <= unlock;
            expire_h_q <= expire;
            wrng_h_q   <= wrng_att;
            seg1_q     <= seg1_d;
            seg2_q     <= seg2_d;
            an1_q      <= an1_d;
            an2_q      <= an2_d;
        end
    end

    assign seg1       = seg1_q;
    assign seg2       = seg2_q;
    assign an1        = an1_q;
    assign an2        = an2_q;
    assign digit_sel  = digit_q;
    assign frame_tick = ftick_q;

endmodule

// File: tb/tb_disp_scan_sched.sv
// Scoreboard bench for disp_scan_sched: a cycle-count based reference
// model predicts every pin, a negedge monitor compares.
module tb_disp_scan_sched;

    localparam int RD = 4;
    localparam int MH = 3;
    localparam int BF = 2;
    localparam int FRAME = 4 * RD;

    logic        clk;
    logic        reset;
    logic        lock, unlock, expire;
    logic [1:0]  wrng_att;
    logic [15:0] user_otp, lfsr_otp;
    logic [6:0]  seg1, seg2;
    logic [3:0]  an1, an2;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    disp_scan_sched #(
        .REFRESH_DIV  (RD),
        .MSG_HOLD     (MH),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lock       (lock),
        .unlock     (unlock),
        .expire     (expire),
        .wrng_att   (wrng_att),
        .user_otp   (user_otp),
        .lfsr_otp   (lfsr_otp),
        .seg1       (seg1),
        .seg2       (seg2),
        .an1        (an1),
        .an2        (an2),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic       ft;
        logic [1:0] ds;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [3:0] a1;
        logic [3:0] a2;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: mode 0=data 1=wrong 2=unlock 3=expire 4=locked
    int   t;
    int   mode;
    int   frames_in_msg;
    int   frames_locked;
    logic p_unl, p_exp;
    logic [1:0] p_wr;
    string HEXS = "0123456789AbCdEF";

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "0": return 7'h40;  "1": return 7'h79;
            "2": return 7'h24;  "3": return 7'h30;
            "4": return 7'h19;  "5": return 7'h12;
            "6": return 7'h02;  "7": return 7'h78;
            "8": return 7'h00;  "9": return 7'h10;
            "A": return 7'h08;  "b": return 7'h03;
            "C": return 7'h46;  "d": return 7'h21;
            "E": return 7'h06;  "F": return 7'h0E;
            "-": return 7'h3F;  "r": return 7'h2F;
            "t": return 7'h07;  "O": return 7'h40;
            "u": return 7'h63;  "P": return 7'h0C;
            "n": return 7'h2B;  "L": return 7'h47;
            default: return 7'h7F;
        endcase
    endfunction

    // What the banks should show for a mode at digit d
    task automatic show(input int m, input int d, input int fl,
                        output logic [6:0] s1, output logic [6:0] s2,
                        output logic [3:0] a);
        string w1;
        byte   c2;
        if (m == 4 && ((fl / BF) % 2) == 1) begin
            s1 = 7'h7F; s2 = 7'h7F; a = 4'hF;
            return;
        end
        a  = 4'hF;
        a[d] = 1'b0;
        c2 = "-";
        case (m)
            0: begin
                s1 = seg_of(HEXS[int'(user_otp[4*d +: 4])]);
                s2 = seg_of(HEXS[int'(lfsr_otp[4*d +: 4])]);
                return;
            end
            1: begin
                w1 = "Err ";
                c2 = (d == 0) ? HEXS[int'(wrng_att)] : " ";
            end
            2: w1 = "OPEn";
            3: w1 = "tOut";
            default: w1 = "LOCd";
        endcase
        s1 = seg_of(w1[3 - d]);
        s2 = seg_of(c2);
    endtask

    // Advance the model by one clock edge and queue the expected pins
    task automatic model_edge();
        obs_t e;
        int   ev;
        int   d_prev;
        bit   ft_prev;
        if (reset) begin
            t = 0; mode = 0; frames_in_msg = 0; frames_locked = 0;
            p_unl = 0; p_exp = 0; p_wr = 0;
            e = '{ft: 1'b0, ds: 2'd0, s1: 7'h7F, s2: 7'h7F,
                  a1: 4'hF, a2: 4'hF};
        end else begin
            d_prev  = (t / RD) % 4;
            ft_prev = (t > 0) && (t % FRAME == 0);
            show(mode, d_prev, frames_locked, e.s1, e.s2, e.a1);
            e.a2 = e.a1;
            ev = 0;
            if (wrng_att != p_wr && wrng_att != 0) ev = 1;
            if (unlock && !p_unl) ev = 2;
            if (expire && !p_exp) ev = 3;
            if (lock) begin
                if (mode != 4) frames_locked = 0;
                else if (ft_prev) frames_locked++;
                mode = 4;
                frames_in_msg = 0;
            end else if (mode == 4) begin
                mode = 0;
            end else if (ev != 0 && ev >= mode) begin
                mode = ev;
                frames_in_msg = 0;
            end else if (mode != 0 && ft_prev) begin
                frames_in_msg++;
                if (frames_in_msg == MH) begin
                    mode = 0;
                    frames_in_msg = 0;
                end
            end
            p_unl = unlock; p_exp = expire; p_wr = wrng_att;
            t++;
            e.ds = 2'((t / RD) % 4);
            e.ft = (t % FRAME == 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    // Monitor: compare every presented output against the scoreboard
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {frame_tick, digit_sel, seg1, seg2, an1, an2};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pins t=%0t got ft=%b ds=%0d s1=%h s2=%h an1=%h an2=%h want ft=%b ds=%0d s1=%h s2=%h an1=%h an2=%h",
                         $time, a.ft, a.ds, a.s1, a.s2, a.a1, a.a2,
                         e.ft, e.ds, e.s1, e.s2, e.a1, e.a2);
            end
        end
    end

    initial begin
        reset = 1'b1; lock = 0; unlock = 0; expire = 0;
        wrng_att = 2'd0; user_otp = 16'h12AF; lfsr_otp = 16'h0000;
        cyc(3);
        reset = 1'b0;
        cyc(40);
        // wrong attempt message, then a silent clear
        wrng_att = 2'd1; cyc(60);
        wrng_att = 2'd0; cyc(20);
        // unlock preempts wrong; later wrong is dropped
        wrng_att = 2'd1; cyc(10);
        unlock = 1; cyc(10);
        wrng_att = 2'd2; cyc(20);
        unlock = 0; cyc(40);
        // simultaneous expire and unlock
        expire = 1; unlock = 1; cyc(60);
        expire = 0; unlock = 0; cyc(10);
        // lockout with blinking
        lock = 1; cyc(90);
        lock = 0; cyc(10);
        // reset mid-frame during an expire message
        expire = 1; cyc(23);
        reset = 1; expire = 0; cyc(1);
        reset = 0; cyc(30);
        // lock already high as reset deasserts
        reset = 1; lock = 1; cyc(2);
        reset = 0; cyc(20);
        lock = 0; cyc(10);
        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) lock = ~lock;
            if ($urandom_range(0, 39) == 0) unlock = ~unlock;
            if ($urandom_range(0, 39) == 0) expire = ~expire;
            if ($urandom_range(0, 29) == 0)
                wrng_att = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) user_otp = 16'($urandom);
            if ($urandom_range(0, 99) == 0) lfsr_otp = 16'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            cyc(1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_sched.md
Name: disp_scan_sched

Overview:
- Time-multiplexed scan scheduler for the two shared 4-digit 7-segment banks of the OTP authentication unit.
- Bank 1 normally shows the user-entered OTP; bank 2 shows the generated OTP.
- Status events (lock, unlock, expire, wrong attempt) preempt the data view with prioritised, time-limited messages.
- Sits between the authentication FSM outputs and the board segment/anode pins, replacing ad-hoc display muxing.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (≥2).
- MSG_HOLD, 250: scan frames a transient message stays on (≥1).
- BLINK_FRAMES, 30: frames per blink half-period in LOCKED (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- lock  in  1  level; system locked out
- unlock  in  1  level; OTP accepted
- expire  in  1  level; OTP expired
- wrng_att  in  2  wrong-attempt count from FSM
- user_otp  in  16  user entry, 4 hex nibbles
- lfsr_otp  in  16  generated OTP, 4 hex nibbles
- seg1  out  7  bank-1 segments {g..a}, active-low
- seg2  out  7  bank-2 segments {g..a}, active-low
- an1  out  4  bank-1 anodes, active-low one-hot
- an2  out  4  bank-2 anodes, active-low one-hot
- digit_sel  out  2  current digit index
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset: seg1=seg2=7'h7F, an1=an2=4'hF, digit_sel=0, frame_tick=0, state SHOW_DATA, all counters 0, edge/history registers 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. slot_tick fires at REFRESH_DIV-1.
- On slot_tick, digit_sel increments mod 4. frame_tick pulses in the cycle digit_sel wraps 3→0.
- seg*/an* are registered: they reflect the new digit_sel 1 cycle after it changes.
- Anode mapping: an = ~(4'b0001 << digit_sel). Digit 0 is the rightmost digit and shows nibble [3:0]; digit 3 shows nibble [15:12].
- Event detection, all registered:
  - Rising edges of lock, unlock and expire.
  - Wrong event = wrng_att differs from its previous value AND the new value is nonzero. A clear to 0 is not an event.
- States and what each displays:
  - SHOW_DATA: hex decode of user_otp on bank 1 and lfsr_otp on bank 2.
  - MSG_WRONG: bank 1 "Err_" (digits 3..0; "_" is blank). Bank 2 digit 0 = hex of wrng_att, other digits blank.
  - MSG_EXPIRE: bank 1 "tOut", bank 2 "----".
  - MSG_UNLOCK: bank 1 "OPEn", bank 2 "----".
  - LOCKED: bank 1 "LOCd", bank 2 "----", blinking.
- Priority: LOCKED > MSG_EXPIRE > MSG_UNLOCK > MSG_WRONG > SHOW_DATA.
- Transitions:
  - An event whose priority is ≥ the current state's enters that state and clears hold_cnt.
  - Lower-priority events are dropped, not queued.
  - Same-cycle events: highest priority wins; the others are dropped.
  - A level-high lock in any state forces LOCKED, including lock already high when reset deasserts.
- hold_cnt: increments on frame_tick in the MSG_* states. On reaching MSG_HOLD-1 with a frame_tick, the state returns to SHOW_DATA.
- LOCKED has no timeout. It exits to SHOW_DATA the cycle after lock is sampled low.
- Blink: blink_cnt counts frames. blink_ph toggles every BLINK_FRAMES frames and is reset to the ON phase on LOCKED entry. In the OFF phase, seg1=seg2=7'h7F and an1=an2=4'hF.
- Scanning never stalls: digit_sel and frame_tick run continuously in every state.
- Reset asserted mid-message or mid-frame returns everything to reset values on the next edge.
- Width rules:
  - prescaler width $clog2(REFRESH_DIV)
  - hold_cnt width $clog2(MSG_HOLD+1)
  - blink_cnt width $clog2(BLINK_FRAMES+1)

Decomposition:
- Shared package disp_pkg contains:
  - State enum: SHOW_DATA, MSG_WRONG, MSG_EXPIRE, MSG_UNLOCK, LOCKED.
  - Active-low glyph constants for 0-F, blank, dash, E, r, t, O, u, P, n, L, C, d.
  - Function hex_to_seg.
- Sub-module seg_glyph_rom: combinational nibble/glyph-code to 7-bit pattern. Instantiated once per bank.
- Scheduler, prescaler and message FSM stay in disp_scan_sched.

Test Plan (REFRESH_DIV=4, MSG_HOLD=3, BLINK_FRAMES=2; frame = 16 cycles):
1. Reset then idle, user_otp=16'h12AF, lfsr_otp=16'h0000 → digit_sel steps every 4 cycles; frame_tick every 16 cycles; at digit_sel=0, an1=4'hE and seg1=glyph F; at digit_sel=3, an1=4'h7 and seg1=glyph 1; seg2=glyph 0 throughout.
2. wrng_att 0→1 → MSG_WRONG; bank 1 shows "Err_" and bank 2 digit 0 shows "1"; returns to SHOW_DATA on the 3rd frame_tick. A later wrng_att 1→0 produces no message.
3. In MSG_WRONG, unlock rises → MSG_UNLOCK with hold restarted. Then wrng_att 1→2 during MSG_UNLOCK → ignored; state stays MSG_UNLOCK.
4. expire and unlock rise in the same cycle → MSG_EXPIRE ("tOut"); the unlock message is never shown.
5. lock held high → LOCKED "LOCd"; displays lit for 2 frames, blank (7'h7F/4'hF) for 2 frames, repeating. lock low → SHOW_DATA on the next cycle.
6. Reset pulsed mid-frame during MSG_EXPIRE → outputs 7'h7F/4'hF and digit_sel=0; SHOW_DATA resumes with the prescaler restarted from 0.
